tdm_demux1x4: RTL and testbench

- Receive-side counterpart of the 4:1 select mux: takes a time-division-multiplexed sample stream (lanes 0..3 sent in slot order) and rebuilds the four parallel lanes.
- Tracks slot position with a 2-bit slot counter aligned by a frame-sync marker.
- Presents each completed 4-lane frame as one registered word with a one-cycle valid pulse.
- Detects lost or misplaced frame sync and recovers from it.

---
 rtl/tdm_demux1x4_pkg.sv | 18 +
 rtl/tdm_demux1x4_if.sv | 28 ++
 rtl/tdm_demux1x4_slot_counter.sv | 30 +++
 rtl/tdm_demux1x4.sv | 155 +++++++++++++++
 tb/tb_tdm_demux1x4.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux1x4_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer and its slot counter.
package tdm_demux1x4_pkg;

    localparam int NUM_LANES = 4;

    // Receiver framing state: HUNT waits for fsync, LOCK tracks slots.
    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Slot index within a 4-lane frame.
    typedef logic [1:0] slot_t;

    localparam slot_t FIRST_SLOT = 2'd0;
    localparam slot_t LAST_SLOT  = 2'd3;

endpackage

// File: rtl/tdm_demux1x4_if.sv
// Bundle of the serial TDM input stream and the rebuilt parallel frame outputs.
interface tdm_demux1x4_if #(
    parameter int WIDTH = 1
);
    import tdm_demux1x4_pkg::*;

    logic [WIDTH-1:0]           din;
    logic                       din_vld;
    logic                       fsync;
    logic [NUM_LANES*WIDTH-1:0] y;
    logic                       y_vld;
    slot_t                      sel;
    logic                       locked;
    logic                       sync_err;

    // Master drives the serial stream and observes the decoded frame.
    modport master (
        output din, din_vld, fsync,
        input  y, y_vld, sel, locked, sync_err
    );

    // Slave is the demultiplexer itself.
    modport slave (
        input  din, din_vld, fsync,
        output y, y_vld, sel, locked, sync_err
    );

endinterface

// File: rtl/tdm_demux1x4_slot_counter.sv
// 2-bit wrapping slot counter with clear and load-to-1; shared with the TDM transmitter.
module tdm_slot_counter
    import tdm_demux1x4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  load1,
    input  logic  clr,
    output slot_t cnt
);

    slot_t cnt_reg;

    // Clear beats load, load beats increment; increment wraps 3 -> 0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= FIRST_SLOT;
        end else if (clr) begin
            cnt_reg <= FIRST_SLOT;
        end else if (load1) begin
            cnt_reg <= slot_t'(1);
        end else if (en) begin
            cnt_reg <= slot_t'(cnt_reg + 2'd1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/tdm_demux1x4.sv
// Receive-side 1:4 TDM demultiplexer: aligns on fsync, rebuilds four lanes,
// publishes each complete frame with a one-cycle valid pulse, and handles sync loss.
module tdm_demux1x4
    import tdm_demux1x4_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MISS_MAX = 2
)(
    input  logic            clk,
    input  logic            rst,
    tdm_demux1x4_if.slave   bus
);

    localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

    state_t                     state_reg;
    logic [3:0]                 miss_reg;
    logic [NUM_LANES*WIDTH-1:0] y_reg;
    logic                       y_vld_reg;
    logic                       sync_err_reg;

    slot_t                      sel;
    logic                       cnt_en;
    logic                       cnt_load1;
    logic                       cnt_clr;
    logic                       shadow_wr;
    slot_t                      shadow_idx;
    logic [3:0]                 miss_next;
    logic                       miss_hit;
    logic [NUM_LANES*WIDTH-1:0] frame_word;

    assign miss_next = miss_reg + 4'd1;
    assign miss_hit  = (miss_next >= MISS_LIM);

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .cnt   (sel)
    );

    // Decide how the slot counter moves and which shadow lane captures din.
    always_comb begin
        cnt_en     = 1'b0;
        cnt_load1  = 1'b0;
        cnt_clr    = 1'b0;
        shadow_wr  = 1'b0;
        shadow_idx = sel;
        if (bus.din_vld) begin
            unique case (state_reg)
                HUNT: begin
                    if (bus.fsync) begin
                        cnt_load1  = 1'b1;
                        shadow_wr  = 1'b1;
                        shadow_idx = FIRST_SLOT;
                    end
                end
                LOCK: begin
                    if (sel == FIRST_SLOT) begin
                        if (bus.fsync || !miss_hit) begin
                            // Genuine or flywheeled slot 0.
                            cnt_en    = 1'b1;
                            shadow_wr = 1'b1;
                        end else begin
                            cnt_clr = 1'b1;
                        end
                    end else if (bus.fsync) begin
                        // Early sync: restart the frame with this sample as lane 0.
                        cnt_load1  = 1'b1;
                        shadow_wr  = 1'b1;
                        shadow_idx = FIRST_SLOT;
                    end else begin
                        cnt_en    = 1'b1;
                        shadow_wr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow lanes 0..2 hold the partial frame; lane 3 comes straight from din.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES - 1; gi++) begin : g_lane
            logic [WIDTH-1:0] lane_reg;

            // Capture din into this lane when its slot is accepted.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (shadow_wr && (shadow_idx == slot_t'(gi))) begin
                    lane_reg <= bus.din;
                end
            end

            assign frame_word[gi*WIDTH +: WIDTH] = lane_reg;
        end
    endgenerate

    assign frame_word[(NUM_LANES-1)*WIDTH +: WIDTH] = bus.din;

    // Framing FSM with registered frame output, valid pulse and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= HUNT;
            miss_reg     <= 4'd0;
            y_reg        <= '0;
            y_vld_reg    <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            y_vld_reg    <= 1'b0;
            sync_err_reg <= 1'b0;
            if (bus.din_vld) begin
                unique case (state_reg)
                    HUNT: begin
                        if (bus.fsync) begin
                            state_reg <= LOCK;
                            miss_reg  <= 4'd0;
                        end
                    end
                    LOCK: begin
                        if (sel == FIRST_SLOT) begin
                            if (bus.fsync) begin
                                miss_reg <= 4'd0;
                            end else if (miss_hit) begin
                                state_reg    <= HUNT;
                                miss_reg     <= 4'd0;
                                sync_err_reg <= 1'b1;
                            end else begin
                                miss_reg <= miss_next;
                            end
                        end else if (bus.fsync) begin
                            miss_reg     <= 4'd0;
                            sync_err_reg <= 1'b1;
                        end else if (sel == LAST_SLOT) begin
                            y_reg     <= frame_word;
                            y_vld_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end

    assign bus.y        = y_reg;
    assign bus.y_vld    = y_vld_reg;
    assign bus.sel      = sel;
    assign bus.locked   = (state_reg == LOCK);
    assign bus.sync_err = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Bench for tdm_demux1x4: directed vector table, async reset sequence,
// then random traffic against a queue-based frame model.
module tb_tdm_demux1x4;

    localparam int MISS_MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux1x4_if #(.WIDTH(1)) bus ();

    tdm_demux1x4 #(.WIDTH(1), .MISS_MAX(MISS_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit         rst_before;
        logic       d;
        logic       v;
        logic       f;
        logic [3:0] y;
        logic       yv;
        logic [1:0] sel;
        logic       lk;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: a frame is just the list of samples gathered so far.
    bit         m_locked;
    logic       m_q[$];
    int         m_misses;
    logic [3:0] m_y;
    logic       m_yv;
    logic       m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input logic [3:0] y, input logic yv,
                             input logic [1:0] sel, input logic lk, input logic err);
        check({tag, ".y"},        32'(bus.y),        32'(y));
        check({tag, ".y_vld"},    32'(bus.y_vld),    32'(yv));
        check({tag, ".sel"},      32'(bus.sel),      32'(sel));
        check({tag, ".locked"},   32'(bus.locked),   32'(lk));
        check({tag, ".sync_err"}, 32'(bus.sync_err), 32'(err));
    endtask

    task automatic drive(input logic d, input logic v, input logic f);
        @(negedge clk);
        bus.din     = d;
        bus.din_vld = v;
        bus.fsync   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.din     = 1'b0;
        bus.din_vld = 1'b0;
        bus.fsync   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void model_reset();
        m_locked = 0;
        m_q.delete();
        m_misses = 0;
        m_y      = 4'h0;
        m_yv     = 1'b0;
        m_err    = 1'b0;
    endfunction

    // One clock edge of the reference: pulses clear, an accepted sample extends the frame.
    function automatic void model_step(input logic d, input logic v, input logic f);
        m_yv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (f) begin
                m_locked = 1;
                m_q      = '{d};
                m_misses = 0;
            end
        end else if (m_q.size() == 0) begin
            if (f) begin
                m_misses = 0;
                m_q.push_back(d);
            end else begin
                m_misses++;
                if (m_misses >= MISS_MAX) begin
                    m_locked = 0;
                    m_err    = 1'b1;
                    m_misses = 0;
                end else begin
                    m_q.push_back(d);
                end
            end
        end else if (f) begin
            m_err    = 1'b1;
            m_q      = '{d};
            m_misses = 0;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
                m_yv = 1'b1;
                m_q.delete();
            end
        end
    endfunction

    initial begin
        bus.din     = 1'b0;
        bus.din_vld = 1'b0;
        bus.fsync   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_all("reset_hold", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_rel", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

        // rst_before, din, din_vld, fsync | y, y_vld, sel, locked, sync_err
        // aligned frame 1,0,1,1
        tbl.push_back('{0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'hD, 1'b1, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b0, 1'b0, 4'hD, 1'b0, 2'd0, 1'b1, 1'b0});
        // data before first fsync, then frame 0,1,1,0
        tbl.push_back('{1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 2'd0, 1'b1, 1'b0});
        // misplaced sync on slot 2, re-align, frame 1,0,0,1
        tbl.push_back('{0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 2'd1, 1'b1, 1'b1});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 2'd0, 1'b1, 1'b0});
        // following frame 0,1,0,0
        tbl.push_back('{0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h9, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 2'd0, 1'b1, 1'b0});
        // flywheel frame 1,1,1,1 without fsync, then second miss drops lock
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0});
        // frame 0,1,1,0 with idle gap (fsync ignored while din_vld=0)
        tbl.push_back('{0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 2'd0, 1'b1, 1'b0});

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            drive(tbl[i].d, tbl[i].v, tbl[i].f);
            $display("vec %0d: din=%0b vld=%0b fs=%0b -> y=%0h y_vld=%0b sel=%0d lk=%0b err=%0b",
                     i, tbl[i].d, tbl[i].v, tbl[i].f, bus.y, bus.y_vld, bus.sel,
                     bus.locked, bus.sync_err);
            check_all($sformatf("vec%0d", i), tbl[i].y, tbl[i].yv, tbl[i].sel, tbl[i].lk, tbl[i].err);
        end

        // Async reset in the middle of a frame, between clock edges.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        check_all("pre_async", 4'h6, 1'b0, 2'd2, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        $display("async reset mid-frame: y=%0h sel=%0d lk=%0b", bus.y, bus.sel, bus.locked);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the frame model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic d, v, f;
            bit at_slot0;
            at_slot0 = !m_locked || (m_q.size() == 0);
            d = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 99) < 75);
            f = at_slot0 ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 6);
            drive(d, v, f);
            model_step(d, v, f);
            if (m_yv || m_err)
                $display("rnd %0d: y=%0h y_vld=%0b err=%0b lk=%0b", c, bus.y, bus.y_vld,
                         bus.sync_err, bus.locked);
            check_all($sformatf("rnd%0d", c), m_y, m_yv,
                      m_locked ? 2'(m_q.size()) : 2'd0, m_locked, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
